// File: rtl/rx_huge_page_pkg.sv
// rx_huge_page_pkg: shared parser states, MWr header constants and DW byte swap for the huge-page ring.
package rx_huge_page_pkg;
  typedef enum logic [2:0] {IDLE, HDR2, DAT3, DAT4, DROP} parse_state_e;
  localparam logic [1:0] FMT_MWR3 = 2'b10;
  localparam logic [1:0] FMT_MWR4 = 2'b11;
  localparam logic [4:0] TYPE_MWR = 5'b00000;
  localparam logic [9:0] LEN_TWO = 10'd2;
  function automatic logic [31:0] dw_swap(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction
endpackage

// File: rtl/rx_mwr_slot_decoder.sv
// rx_mwr_slot_decoder: parses 64-bit TRN RX MWr TLPs that post a 64-bit page address into a slot register.
module rx_mwr_slot_decoder
  import rx_huge_page_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int IDX_W = $clog2(NUM_PAGES),
  parameter int BAR_IDX = 0,
  parameter logic [11:0] REG_BASE = 12'h100
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [63:0]      rd_i,
  input  logic             sof_n_i,
  input  logic             eof_n_i,
  input  logic             src_rdy_n_i,
  input  logic             dst_rdy_n_i,
  input  logic             dsc_n_i,
  input  logic             errfwd_n_i,
  input  logic [6:0]       bar_hit_n_i,
  output logic             commit_valid_o,
  output logic [IDX_W-1:0] slot_idx_o,
  output logic [63:0]      addr_o
);
  parse_state_e state_q, state_d;
  logic fmt4_q, fmt4_d, ok_q, ok_d, poison_q, poison_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic [31:0] d0_q, d0_d;
  logic beat, eof, poison_now, hdr_ok, addr_ok;
  logic [11:0] aoff;
  logic [8:0] off;
  assign beat = !src_rdy_n_i && !dst_rdy_n_i;
  assign eof = !eof_n_i;
  assign poison_now = !errfwd_n_i;
  assign hdr_ok = (rd_i[62:61] == FMT_MWR3 || rd_i[62:61] == FMT_MWR4) && rd_i[60:56] == TYPE_MWR &&
                  rd_i[41:32] == LEN_TWO && rd_i[7:0] == 8'hFF && !bar_hit_n_i[BAR_IDX];
  // Slot offset is taken modulo the 9-bit field, so one compare covers both range ends.
  assign aoff = fmt4_q ? rd_i[11:0] : rd_i[43:32];
  assign off = aoff[11:3] - REG_BASE[11:3];
  assign addr_ok = off < 9'(NUM_PAGES) && aoff[2:0] == 3'b000;
  assign slot_idx_o = slot_q;
  assign addr_o = state_q == DAT4 ? {dw_swap(rd_i[31:0]), dw_swap(rd_i[63:32])}
                                  : {dw_swap(rd_i[63:32]), dw_swap(d0_q)};
  always_comb begin
    state_d = state_q;
    fmt4_d = fmt4_q;
    ok_d = ok_q;
    poison_d = poison_q;
    slot_d = slot_q;
    d0_d = d0_q;
    commit_valid_o = 1'b0;
    if (!dsc_n_i) state_d = IDLE;
    else if (beat) begin
      poison_d = poison_q | poison_now;
      case (state_q)
        IDLE: if (!sof_n_i) begin
          fmt4_d = rd_i[61];
          ok_d = hdr_ok;
          poison_d = poison_now;
          state_d = eof ? IDLE : HDR2;
        end
        HDR2: begin
          d0_d = rd_i[31:0];
          slot_d = off[IDX_W-1:0];
          state_d = eof ? IDLE : !(ok_q && addr_ok) ? DROP : fmt4_q ? DAT4 : DAT3;
        end
        DAT3, DAT4: begin
          commit_valid_o = eof && !poison_q && !poison_now;
          state_d = IDLE;
        end
        default: state_d = eof ? IDLE : DROP;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      fmt4_q <= 1'b0;
      ok_q <= 1'b0;
      poison_q <= 1'b0;
      slot_q <= '0;
      d0_q <= '0;
    end else begin
      state_q <= state_d;
      fmt4_q <= fmt4_d;
      ok_q <= ok_d;
      poison_q <= poison_d;
      slot_q <= slot_d;
      d0_q <= d0_d;
    end
  end
endmodule

// File: rtl/rx_huge_page_ring.sv
// rx_huge_page_ring: ring of host-posted huge-page addresses presented as current plus prefetched next page.
module rx_huge_page_ring
  import rx_huge_page_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int IDX_W = $clog2(NUM_PAGES),
  parameter int BAR_IDX = 0,
  parameter logic [11:0] REG_BASE = 12'h100
) (
  input  logic             trn_clk,
  input  logic             trn_reset_n,
  input  logic [63:0]      trn_rd,
  input  logic [7:0]       trn_rrem_n,
  input  logic             trn_rsof_n,
  input  logic             trn_reof_n,
  input  logic             trn_rsrc_rdy_n,
  input  logic             trn_rsrc_dsc_n,
  input  logic             trn_rerrfwd_n,
  input  logic [6:0]       trn_rbar_hit_n,
  input  logic             trn_rdst_rdy_n,
  output logic [63:0]      page_addr,
  output logic             page_valid,
  output logic [63:0]      next_page_addr,
  output logic             next_page_valid,
  input  logic             page_free,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W:0]   pages_avail,
  output logic             overwrite_err,
  output logic             free_err
);
  localparam int AW = IDX_W + 1;
  logic cv, free_ok, wr;
  logic [IDX_W-1:0] cslot, head_q, head_d, nxt_d;
  logic [63:0] caddr;
  logic [NUM_PAGES-1:0] valid_q, valid_d;
  logic [63:0] addr_q [NUM_PAGES];
  logic [63:0] addr_d [NUM_PAGES];
  logic [AW-1:0] avail_q, avail_d;
  logic [63:0] page_addr_q, next_addr_q;
  logic page_valid_q, next_valid_q, ovr_q, ferr_q;
  logic unused_rrem;
  assign unused_rrem = ^trn_rrem_n;
  rx_mwr_slot_decoder #(
    .NUM_PAGES(NUM_PAGES), .IDX_W(IDX_W), .BAR_IDX(BAR_IDX), .REG_BASE(REG_BASE)
  ) u_dec (
    .clk_i(trn_clk), .rst_n_i(trn_reset_n), .rd_i(trn_rd), .sof_n_i(trn_rsof_n),
    .eof_n_i(trn_reof_n), .src_rdy_n_i(trn_rsrc_rdy_n), .dst_rdy_n_i(trn_rdst_rdy_n),
    .dsc_n_i(trn_rsrc_dsc_n), .errfwd_n_i(trn_rerrfwd_n), .bar_hit_n_i(trn_rbar_hit_n),
    .commit_valid_o(cv), .slot_idx_o(cslot), .addr_o(caddr)
  );
  assign page_addr = page_addr_q;
  assign page_valid = page_valid_q;
  assign next_page_addr = next_addr_q;
  assign next_page_valid = next_valid_q;
  assign head_idx = head_q;
  assign pages_avail = avail_q;
  assign overwrite_err = ovr_q;
  assign free_err = ferr_q;
  // Commit checks pre-edge validity, so a write to the head being freed is refused.
  always_comb begin
    free_ok = page_free && valid_q[head_q];
    wr = cv && !valid_q[cslot];
    valid_d = valid_q;
    addr_d = addr_q;
    if (free_ok) begin
      valid_d[head_q] = 1'b0;
      addr_d[head_q] = '0;
    end
    if (wr) begin
      valid_d[cslot] = 1'b1;
      addr_d[cslot] = caddr;
    end
    head_d = free_ok ? head_q + IDX_W'(1) : head_q;
    nxt_d = head_d + IDX_W'(1);
    avail_d = avail_q + AW'(wr) - AW'(free_ok);
  end
  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      valid_q <= '0;
      addr_q <= '{default: '0};
      head_q <= '0;
      avail_q <= '0;
      page_addr_q <= '0;
      next_addr_q <= '0;
      page_valid_q <= 1'b0;
      next_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      head_q <= head_d;
      avail_q <= avail_d;
      page_addr_q <= addr_d[head_d];
      next_addr_q <= addr_d[nxt_d];
      page_valid_q <= valid_d[head_d];
      next_valid_q <= valid_d[nxt_d];
      ovr_q <= ovr_q | (cv && valid_q[cslot]);
      ferr_q <= ferr_q | (page_free && !valid_q[head_q]);
    end
  end
endmodule

// File: tb/tb_rx_huge_page_ring.sv
// tb_rx_huge_page_ring: directed TLP vectors and ring sequences against hand-computed slot state.
module tb_rx_huge_page_ring;
  logic trn_clk = 1'b0, trn_reset_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic [7:0] trn_rrem_n = '0;
  logic trn_rsof_n = 1'b1, trn_reof_n = 1'b1, trn_rsrc_rdy_n = 1'b1, trn_rsrc_dsc_n = 1'b1;
  logic trn_rerrfwd_n = 1'b1, trn_rdst_rdy_n = 1'b0, page_free = 1'b0;
  logic [6:0] trn_rbar_hit_n = 7'h7E;
  logic [63:0] page_addr, next_page_addr;
  logic page_valid, next_page_valid, overwrite_err, free_err;
  logic [1:0] head_idx;
  logic [2:0] pages_avail;
  int n_chk = 0, n_fail = 0;

  localparam logic [31:0] W3 = 32'h4000_0002, W4 = 32'h6000_0002;
  localparam logic [6:0] BAR0 = 7'h7E, BAR1 = 7'h7D;
  localparam logic [63:0] S1 = 64'h0000_0001_0020_0000, A0 = 64'h0000_0002_4000_0000;
  localparam logic [63:0] A2 = 64'h0000_0002_4020_0000, A3 = 64'h0000_0002_4040_0000;
  localparam logic [63:0] B0 = 64'h0000_0003_0000_0000, B1 = 64'h0000_0003_0020_0000;
  localparam logic [63:0] X = 64'hDEAD_BEEF_0000_0000;

  rx_huge_page_ring dut (
    .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rerrfwd_n(trn_rerrfwd_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .page_addr(page_addr), .page_valid(page_valid),
    .next_page_addr(next_page_addr), .next_page_valid(next_page_valid), .page_free(page_free),
    .head_idx(head_idx), .pages_avail(pages_avail), .overwrite_err(overwrite_err), .free_err(free_err)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic [63:0] b0, b1, b2;
    int nb, dsc_at, poi_at;
    logic [6:0] bar;
    int ea;
    bit epv, enpv;
    logic [63:0] epa, ena;
  } vec_t;

  function automatic logic [31:0] sw(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic vec_t mk(input bit is4, input logic [31:0] dw0, input logic [7:0] be,
                              input logic [31:0] a, input logic [63:0] val, input logic [6:0] bar,
                              input int dsc_at, input int poi_at, input int ea, input bit epv,
                              input bit enpv, input logic [63:0] epa, input logic [63:0] ena);
    vec_t t;
    logic [31:0] d0, d1;
    d0 = sw(val[31:0]);
    d1 = sw(val[63:32]);
    t.b0 = {dw0, 24'h0, be};
    t.b1 = is4 ? {32'h0, a} : {a, d0};
    t.b2 = is4 ? {d0, d1} : {d1, 32'h0};
    t.nb = 3;
    t.dsc_at = dsc_at;
    t.poi_at = poi_at;
    t.bar = bar;
    t.ea = ea;
    t.epv = epv;
    t.enpv = enpv;
    t.epa = epa;
    t.ena = ena;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int ea, input bit epv, input bit enpv,
                           input logic [63:0] epa, input logic [63:0] ena);
    chk({tag, " pages_avail"}, 64'(pages_avail), 64'(ea));
    chk({tag, " page_valid"}, 64'(page_valid), 64'(epv));
    chk({tag, " next_page_valid"}, 64'(next_page_valid), 64'(enpv));
    chk({tag, " page_addr"}, page_addr, epa);
    chk({tag, " next_page_addr"}, next_page_addr, ena);
  endtask

  task automatic idle_bus();
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    trn_rerrfwd_n = 1'b1;
    trn_rbar_hit_n = BAR0;
    page_free = 1'b0;
  endtask

  task automatic send(input vec_t t, input int free_at, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge trn_clk);
      trn_rd = (i == 0) ? t.b0 : (i == 1) ? t.b1 : t.b2;
      trn_rsof_n = (i != 0);
      trn_reof_n = (i != t.nb - 1);
      trn_rsrc_rdy_n = 1'b0;
      trn_rsrc_dsc_n = (i != t.dsc_at);
      trn_rerrfwd_n = (i != t.poi_at);
      trn_rbar_hit_n = t.bar;
      page_free = (i == free_at);
    end
    @(negedge trn_clk);
    idle_bus();
  endtask

  task automatic free_pulse();
    @(negedge trn_clk);
    page_free = 1'b1;
    @(negedge trn_clk);
    page_free = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk_state(tag, 0, 0, 0, 64'h0, 64'h0);
    chk({tag, " head_idx"}, 64'(head_idx), 64'h0);
    chk({tag, " overwrite_err"}, 64'(overwrite_err), 64'h0);
    chk({tag, " free_err"}, 64'(free_err), 64'h0);
  endtask

  initial begin
    vec_t v [11];
    vec_t t;
    v[0] = mk(0, W3, 8'hFF, 32'h108, S1, BAR0, -1, -1, 1, 0, 1, 64'h0, S1);
    v[1] = mk(0, W3, 8'hFF, 32'h100, X, BAR0, 2, -1, 1, 0, 1, 64'h0, S1);
    v[2] = mk(0, W3, 8'hFF, 32'h100, X, BAR0, -1, 1, 1, 0, 1, 64'h0, S1);
    v[3] = mk(0, 32'h4000_0001, 8'hFF, 32'h100, X, BAR0, -1, -1, 1, 0, 1, 64'h0, S1);
    v[4] = mk(0, W3, 8'hFF, 32'h100, X, BAR1, -1, -1, 1, 0, 1, 64'h0, S1);
    v[5] = mk(0, W3, 8'hFF, 32'h120, X, BAR0, -1, -1, 1, 0, 1, 64'h0, S1);
    v[6] = mk(0, 32'h0000_0002, 8'hFF, 32'h100, X, BAR0, -1, -1, 1, 0, 1, 64'h0, S1);
    v[6].nb = 2;
    v[7] = mk(0, W3, 8'hFF, 32'h10C, X, BAR0, -1, -1, 1, 0, 1, 64'h0, S1);
    v[8] = mk(1, W4, 8'hFF, 32'h100, A0, BAR0, -1, -1, 2, 1, 1, A0, S1);
    v[9] = mk(0, W3, 8'hFF, 32'h118, A3, BAR0, -1, -1, 3, 1, 1, A0, S1);
    v[10] = mk(0, W3, 8'h0F, 32'h110, X, BAR0, -1, -1, 3, 1, 1, A0, S1);

    repeat (3) @(negedge trn_clk);
    trn_reset_n = 1'b1;
    chk_zero("reset");

    for (int i = 0; i < 11; i++) begin
      send(v[i], -1, 0, v[i].nb - 1);
      chk_state($sformatf("vec%0d", i), v[i].ea, v[i].epv, v[i].enpv, v[i].epa, v[i].ena);
      chk($sformatf("vec%0d head_idx", i), 64'(head_idx), 64'h0);
      chk($sformatf("vec%0d overwrite_err", i), 64'(overwrite_err), 64'h0);
    end

    send(mk(0, W3, 8'hFF, 32'h100, X, BAR0, -1, -1, 0, 0, 0, 0, 0), -1, 0, 2);
    chk_state("rewrite", 3, 1, 1, A0, S1);
    chk("rewrite overwrite_err", 64'(overwrite_err), 64'h1);

    send(mk(1, W4, 8'hFF, 32'h110, A2, BAR0, -1, -1, 0, 0, 0, 0, 0), -1, 0, 2);
    chk_state("full", 4, 1, 1, A0, S1);
    free_pulse();
    chk_state("free1", 3, 1, 1, S1, A2);
    chk("free1 head_idx", 64'(head_idx), 64'h1);
    free_pulse();
    chk_state("free2", 2, 1, 1, A2, A3);
    chk("free2 head_idx", 64'(head_idx), 64'h2);
    free_pulse();
    chk_state("free3", 1, 1, 0, A3, 64'h0);
    chk("free3 head_idx", 64'(head_idx), 64'h3);
    free_pulse();
    chk_state("free4", 0, 0, 0, 64'h0, 64'h0);
    chk("free4 head_idx", 64'(head_idx), 64'h0);
    chk("free4 free_err", 64'(free_err), 64'h0);
    free_pulse();
    chk("empty free free_err", 64'(free_err), 64'h1);
    chk("empty free head_idx", 64'(head_idx), 64'h0);
    chk("empty free pages_avail", 64'(pages_avail), 64'h0);

    @(negedge trn_clk);
    trn_reset_n = 1'b0;
    @(negedge trn_clk);
    trn_reset_n = 1'b1;
    chk_zero("reset2");
    send(mk(0, W3, 8'hFF, 32'h100, B0, BAR0, -1, -1, 0, 0, 0, 0, 0), -1, 0, 2);
    send(mk(1, W4, 8'hFF, 32'h108, B1, BAR0, -1, -1, 0, 0, 0, 0, 0), -1, 0, 2);
    chk_state("pre-collide", 2, 1, 1, B0, B1);
    send(mk(0, W3, 8'hFF, 32'h100, X, BAR0, -1, -1, 0, 0, 0, 0, 0), 2, 0, 2);
    chk_state("collide", 1, 1, 0, B1, 64'h0);
    chk("collide head_idx", 64'(head_idx), 64'h1);
    chk("collide overwrite_err", 64'(overwrite_err), 64'h1);

    t = mk(0, W3, 8'hFF, 32'h110, A2, BAR0, -1, -1, 0, 0, 0, 0, 0);
    send(t, -1, 0, 1);
    trn_reset_n = 1'b0;
    @(negedge trn_clk);
    trn_reset_n = 1'b1;
    chk_zero("reset mid-tlp");
    send(t, -1, 2, 2);
    chk_zero("stale tail");
    send(v[0], -1, 0, 2);
    chk_state("after reset", 1, 0, 1, 64'h0, S1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_huge_page_ring.md
Name: rx_huge_page_ring

Overview:
Parametrised successor to the two-slot huge-page address register block. Snoops the 64-bit TRN RX stream for host memory writes that post N huge-page bus addresses into a slot array. Presents them in strict ring order to the packet-to-hugepage writer as a current page plus a prefetched next page, so the writer can change pages without a bubble. Instantiated in the PCIe endpoint application beside the MDIO host interface, in the trn_clk domain.

Parameters:
NUM_PAGES, 4, number of huge-page slots; power of two, 2..16
IDX_W, $clog2(NUM_PAGES), slot index width (derived; do not override)
BAR_IDX, 0, trn_rbar_hit_n bit that selects this block
REG_BASE, 12'h100, BAR byte offset of slot 0; slot i is at REG_BASE + 8*i; 8-byte aligned

Ports:
trn_clk  in  1  core clock
trn_reset_n  in  1  synchronous reset, active-low
trn_rd  in  64  RX data
trn_rrem_n  in  8  RX remainder (ignored; length is taken from the header)
trn_rsof_n  in  1  RX start of frame
trn_reof_n  in  1  RX end of frame
trn_rsrc_rdy_n  in  1  RX source ready
trn_rsrc_dsc_n  in  1  RX discontinue
trn_rerrfwd_n  in  1  RX poisoned TLP
trn_rbar_hit_n  in  7  BAR hit
trn_rdst_rdy_n  in  1  RX destination ready (a beat is accepted when rsrc_rdy_n and rdst_rdy_n are both low)
page_addr  out  64  address held in the head slot
page_valid  out  1  head slot is filled
next_page_addr  out  64  address held in slot head+1 (mod N)
next_page_valid  out  1  slot head+1 is filled
page_free  in  1  one-cycle pulse: consumer has finished the head page
head_idx  out  IDX_W  current head slot
pages_avail  out  IDX_W+1  number of filled slots
overwrite_err  out  1  sticky: host wrote a slot that was already filled
free_err  out  1  sticky: page_free arrived while page_valid was 0

Behaviour:
- Reset (trn_reset_n=0 at a clock edge): all slots invalid; all addresses 0; head_idx=0; pages_avail=0; both sticky errors 0; parser FSM to IDLE. All outputs read 0 the cycle after reset. A TLP in flight during reset is dropped. Work resumes at the next sof after reset is released.
- A TLP is accepted only if all of these hold:
  - fmt/type is MWr: DW0[30:29]=2'b10 (3DW) or 2'b11 (4DW), and DW0[28:24]=0
  - length DW0[9:0]=2, and the first/last byte enables DW1[7:0]=8'hFF
  - trn_rbar_hit_n[BAR_IDX]=0
  - address bits [11:3] fall within REG_BASE[11:3] .. +NUM_PAGES-1, and address bits [2:0]=0
  - Every other TLP is ignored with no side effects.
- Parser FSM, advancing only on accepted beats:
  - IDLE: on sof, latch DW0/DW1 and go to HDR2.
  - HDR2: 3DW header: address is trn_rd[63:32] and payload D0 is trn_rd[31:0]; go to DAT3. 4DW header: low address is trn_rd[31:0]; go to DAT4. A mismatch on any accept check goes to DROP.
  - DAT3: D1 is trn_rd[63:32]; eof is required; commit; go to IDLE.
  - DAT4: D0 is trn_rd[63:32] and D1 is trn_rd[31:0]; eof is required; commit; go to IDLE.
  - DROP: wait for eof, then go to IDLE.
  - From any state, discontinue (rsrc_dsc_n=0), or eof arriving earlier or later than expected, returns to IDLE with no commit.
  - Poison (rerrfwd_n=0) on any beat suppresses the commit.
- Payload is little-endian. Each DW is byte-swapped, {b0,b1,b2,b3}, and the slot address is {swap(D1), swap(D0)}.
- Commit to slot s:
  - If s is invalid: store the address and set valid; pages_avail increments. The slot reads valid on the outputs 1 cycle after the eof beat.
  - If s is valid: the write is dropped and overwrite_err is set.
- page_free with page_valid=1: the head slot is cleared and head_idx advances (wrapping N-1 to 0). The outputs reflect the new head on the next cycle. pages_avail decrements.
- page_free with page_valid=0: no change to head or slots; free_err is set.
- Commit and page_free in the same cycle:
  - The commit's valid check uses pre-edge slot state. A write to the head slot being freed is therefore dropped and flagged.
  - pages_avail nets to unchanged when both succeed.
- page_addr, next_page_addr and both valid flags are registered outputs. There is no combinational path from any input to any output.
- pages_avail never exceeds NUM_PAGES and never goes below 0.

Decomposition:
- Package rx_huge_page_pkg holds:
  - the parser state enum (IDLE, HDR2, DAT3, DAT4, DROP)
  - the MWr fmt/type constants
  - the length-2 constant
  - a DW byte-swap function
- One sub-module, rx_mwr_slot_decoder: a 64-bit TRN MWr parser. It outputs a one-cycle commit_valid, slot_idx and addr. The top holds the slot array, the head pointer and the error flags.

Test Plan (N=4, REG_BASE=0x100, BAR0):
- 3DW MWr to offset 0x108, payload bytes 00 00 20 00 / 01 00 00 00 -> slot1=64'h0000_0001_0020_0000, pages_avail=1, page_valid=0 (head is 0), next_page_valid=1.
- 4DW MWr to offsets 0x100, 0x108, 0x110, 0x118 with addresses A0..A3, then 4 page_free pulses -> page_addr steps A0, A1, A2, A3; next_page_addr leads by one slot; head_idx wraps to 0; pages_avail=0.
- Rewrite slot0 while it is valid -> value unchanged and overwrite_err=1. page_free while empty -> free_err=1 and head_idx unchanged.
- TLPs that are dropped with no state change:
  - rsrc_dsc_n pulsed on the data beat
  - rerrfwd_n asserted
  - length=1
  - BAR1 hit
  - offset 0x120
  - MRd to 0x100
- Head slot full, with page_free and a commit to the head slot in the same cycle -> head advances, the write is dropped, overwrite_err=1, pages_avail decrements by 1.
- Reset asserted mid-TLP (after HDR2) -> all outputs 0. The next full MWr after release commits normally.
